// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, PC source select, fetch redirect FSM state and the NOP word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // PC source select. The hazard unit drives it, and fetch_stage is its only consumer.
  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_JR  = 2'd1,
    PC_J   = 2'd2,
    PC_BR  = 2'd3
  } pcsel_t;

  // PENDING means a redirect arrived while the PC was stalled and has not been applied yet.
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } fetch_state_t;

  localparam word_t NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of signals between the fetch stage and its neighbours (hazard unit, execute, I-memory, decode).
// Latency: n/a (wires only).
// Backpressure: pcen/deen act as stall enables; iREN is the only request to I-memory.
// Ports: master drives control, targets and imemload, and observes fetch outputs. slave is the fetch stage.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic   pcen;
  pcsel_t PCSel;
  logic   deen;
  logic   deflush;
  word_t  jr_target;
  word_t  br_target;
  logic   halt;
  word_t  imemload;
  logic   iREN;
  word_t  imemaddr;
  word_t  de_instr;
  word_t  de_npc;
  logic   de_valid;
  logic   redirect_pending;

  modport master (
    output pcen, PCSel, deen, deflush, jr_target, br_target, halt, imemload,
    input  iREN, imemaddr, de_instr, de_npc, de_valid, redirect_pending
  );

  modport slave (
    input  pcen, PCSel, deen, deflush, jr_target, br_target, halt, imemload,
    output iREN, imemaddr, de_instr, de_npc, de_valid, redirect_pending
  );

endinterface

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC candidate mux. Selects PC+4, the jr target, the jump target or the branch target.
// Latency: purely combinational.
// Backpressure: none. The caller decides whether the candidate is taken, captured or ignored.
// Ports: pcsel_i select, jr/br targets, IF/DE slices for the jump target, pc_plus4_i; target_o is the chosen PC.
module next_pc_sel
  import cpu_types_pkg::*;
(
  input  pcsel_t      pcsel_i,
  input  word_t       jr_target_i,
  input  word_t       br_target_i,
  input  logic [3:0]  npc_hi_i,     // de_npc[31:28]
  input  logic [25:0] instr_idx_i,  // de_instr[25:0]
  input  word_t       pc_plus4_i,
  output word_t       target_o
);

  // The jump is sitting in decode when PCSel selects it, so the target is built from IF/DE contents.
  word_t jtgt;
  assign jtgt = {npc_hi_i, instr_idx_i, 2'b00};

  always_comb begin
    target_o = pc_plus4_i;
    case (pcsel_i)
      PC_JR:   target_o = jr_target_i;
      PC_J:    target_o = jtgt;
      PC_BR:   target_o = br_target_i;
      default: target_o = pc_plus4_i;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect-pending FSM, halt flag and IF/DE pipeline latch.
// Latency: imemaddr is the current PC (combinational). IF/DE and the PC update one cycle after the enables.
// Backpressure: pcen stalls the PC, and a redirect seen during the stall is kept; deen stalls IF/DE; halt freezes everything but deflush.
// Ports: CLK, RST (synchronous, active-high); bus is the slave side of fetch_stage_if.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_RESET  = 32'h0000_0000,
  parameter word_t NOP_INSTR = NOP
)(
  input  logic          CLK,
  input  logic          RST,
  fetch_stage_if.slave  bus
);

  word_t        pc_q, pc_d;
  word_t        pend_q, pend_d;
  fetch_state_t state_q, state_d;
  logic         halted_q, halted_d;
  word_t        de_instr_q, de_instr_d;
  word_t        de_npc_q, de_npc_d;
  logic         de_valid_q, de_valid_d;

  word_t pc_plus4;
  word_t sel_tgt;
  logic  frozen;
  logic  redirect;
  logic  take_pend;

  assign pc_plus4 = pc_q + 32'd4;  // mod 2^32; the wrap to 0 is intended
  assign redirect = (bus.PCSel != PC_SEQ);
  // A halt arriving this edge already wins over a same-cycle redirect.
  assign frozen    = halted_q | bus.halt;
  assign take_pend = ~frozen & bus.pcen & ~redirect & (state_q == PENDING);

  next_pc_sel u_next_pc_sel (
    .pcsel_i     (bus.PCSel),
    .jr_target_i (bus.jr_target),
    .br_target_i (bus.br_target),
    .npc_hi_i    (de_npc_q[31:28]),
    .instr_idx_i (de_instr_q[25:0]),
    .pc_plus4_i  (pc_plus4),
    .target_o    (sel_tgt)
  );

  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    state_d    = state_q;
    halted_d   = halted_q | bus.halt;
    de_instr_d = de_instr_q;
    de_npc_d   = de_npc_q;
    de_valid_d = de_valid_q;

    if (!frozen) begin
      if (bus.pcen) begin
        // A fresh redirect beats a pending one, and the pending one is dropped.
        if (redirect)               pc_d = sel_tgt;
        else if (state_q == PENDING) pc_d = pend_q;
        else                         pc_d = pc_plus4;
        state_d = IDLE;
      end else if (redirect) begin
        // Latest redirect seen during the stall wins.
        pend_d  = sel_tgt;
        state_d = PENDING;
      end
    end

    if (bus.deflush) begin
      de_instr_d = NOP_INSTR;
      de_npc_d   = '0;
      de_valid_d = 1'b0;
    end else if (!frozen && bus.deen) begin
      if (take_pend) begin
        // The word fetched at the stalled PC is on the wrong path.
        de_instr_d = NOP_INSTR;
        de_npc_d   = '0;
        de_valid_d = 1'b0;
      end else begin
        de_instr_d = bus.imemload;
        de_npc_d   = pc_plus4;
        de_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q       <= PC_RESET;
      pend_q     <= '0;
      state_q    <= IDLE;
      halted_q   <= 1'b0;
      de_instr_q <= NOP_INSTR;
      de_npc_q   <= '0;
      de_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      halted_q   <= halted_d;
      de_instr_q <= de_instr_d;
      de_npc_q   <= de_npc_d;
      de_valid_q <= de_valid_d;
    end
  end

  assign bus.imemaddr         = pc_q;
  assign bus.iREN             = ~halted_q;
  assign bus.de_instr         = de_instr_q;
  assign bus.de_npc           = de_npc_q;
  assign bus.de_valid         = de_valid_q;
  assign bus.redirect_pending = (state_q == PENDING);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  fetch_stage_if bus ();

  fetch_stage #(.PC_RESET(32'h0), .NOP_INSTR(32'h0)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state, described as architectural quantities.
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_tgt;
  bit          m_halted;
  logic [31:0] m_di, m_dn;
  bit          m_dv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit pc_en, input int sel, input bit de_en, input bit flush, input bit hlt, input bit rst);
    bus.pcen    = pc_en;
    bus.PCSel   = pcsel_t'(sel[1:0]);
    bus.deen    = de_en;
    bus.deflush = flush;
    bus.halt    = hlt;
    RST         = rst;
  endtask

  // Redirect destination for a select value, from the current decode contents.
  function automatic logic [31:0] target(input int sel);
    case (sel)
      1:       return bus.jr_target;
      2:       return (m_dn & 32'hF000_0000) | ((m_di & 32'h03FF_FFFF) << 2);
      3:       return bus.br_target;
      default: return m_pc + 32'd4;
    endcase
  endfunction

  // Apply one clock edge. The model predicts the result, then all outputs are compared.
  task automatic cycle();
    logic [31:0] n_pc, n_pt, n_di, n_dn;
    bit n_pend, n_halt, n_dv, stop, squash;
    int sel;
    sel    = int'(bus.PCSel);
    n_pc   = m_pc; n_pend = m_pend; n_pt = m_pend_tgt;
    n_di   = m_di; n_dn = m_dn; n_dv = m_dv;
    n_halt = m_halted || bus.halt;
    stop   = m_halted || bus.halt;
    squash = 0;
    if (RST) begin
      n_pc = 0; n_pend = 0; n_pt = 0; n_halt = 0; n_di = 0; n_dn = 0; n_dv = 0;
    end else begin
      if (!stop && bus.pcen) begin
        if (sel != 0) n_pc = target(sel);
        else if (m_pend) begin n_pc = m_pend_tgt; squash = 1; end
        else n_pc = m_pc + 32'd4;
        n_pend = 0;
      end else if (!stop && sel != 0) begin
        n_pend = 1; n_pt = target(sel);
      end
      if (bus.deflush || (!stop && bus.deen && squash)) begin
        n_di = 0; n_dn = 0; n_dv = 0;
      end else if (!stop && bus.deen) begin
        n_di = bus.imemload; n_dn = m_pc + 32'd4; n_dv = 1;
      end
    end
    @(posedge CLK);
    #1;
    m_pc = n_pc; m_pend = n_pend; m_pend_tgt = n_pt; m_halted = n_halt;
    m_di = n_di; m_dn = n_dn; m_dv = n_dv;
    chk("imemaddr", bus.imemaddr, m_pc);
    chk("iREN", 32'(bus.iREN), 32'(!m_halted));
    chk("de_instr", bus.de_instr, m_di);
    chk("de_npc", bus.de_npc, m_dn);
    chk("de_valid", 32'(bus.de_valid), 32'(m_dv));
    chk("redirect_pending", 32'(bus.redirect_pending), 32'(m_pend));
  endtask

  initial begin
    m_pc = 0; m_pend = 0; m_pend_tgt = 0; m_halted = 0; m_di = 0; m_dn = 0; m_dv = 0;
    bus.jr_target = 0; bus.br_target = 0; bus.imemload = 32'h2001_0005;
    drive(0, 0, 0, 0, 0, 1);

    // Reset, then straight-line fetch.
    cycle();
    chk("reset_pc", bus.imemaddr, 32'h0);
    chk("reset_iren", 32'(bus.iREN), 32'h1);
    chk("reset_valid", 32'(bus.de_valid), 32'h0);
    drive(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("seq_pc", bus.imemaddr, 32'hC);
    chk("seq_npc", bus.de_npc, 32'hC);
    chk("seq_valid", 32'(bus.de_valid), 32'h1);
    for (int i = 0; i < 16 && bus.imemaddr != 32'h20; i++) cycle();
    chk("reach_20", bus.imemaddr, 32'h20);

    // Jump from decode with a simultaneous flush.
    bus.imemload = 32'h0800_0010;
    cycle();
    chk("j_instr", bus.de_instr, 32'h0800_0010);
    chk("j_npc", bus.de_npc, 32'h24);
    drive(1, 2, 1, 1, 0, 0);
    cycle();
    chk("jump_pc", bus.imemaddr, 32'h40);
    chk("jump_bubble", 32'(bus.de_valid), 32'h0);

    // jr during a PC stall, applied once the PC is re-enabled.
    bus.jr_target = 32'h100;
    drive(0, 1, 0, 1, 0, 0);
    cycle();
    chk("jr_pend", 32'(bus.redirect_pending), 32'h1);
    chk("jr_hold", bus.imemaddr, 32'h40);
    drive(1, 0, 1, 0, 0, 0);
    cycle();
    chk("jr_pc", bus.imemaddr, 32'h100);
    chk("jr_squash", 32'(bus.de_valid), 32'h0);
    chk("jr_clear", 32'(bus.redirect_pending), 32'h0);

    // A branch with pcen beats an older pending redirect.
    drive(0, 1, 0, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    chk("br_pend_held", 32'(bus.redirect_pending), 32'h1);
    bus.br_target = 32'h200;
    drive(1, 3, 1, 0, 0, 0);
    cycle();
    chk("br_pc", bus.imemaddr, 32'h200);
    chk("br_clear", 32'(bus.redirect_pending), 32'h0);
    drive(1, 0, 1, 0, 0, 0);
    cycle();
    chk("br_next", bus.imemaddr, 32'h204);

    // The PC wraps past the top of the address space.
    bus.jr_target = 32'hFFFF_FFFC;
    drive(1, 1, 1, 0, 0, 0);
    cycle();
    drive(1, 0, 1, 0, 0, 0);
    cycle();
    chk("wrap_pc", bus.imemaddr, 32'h0);
    chk("wrap_npc", bus.de_npc, 32'h0);

    // Flush beats a stalled latch, then the latch holds while stalled.
    drive(0, 0, 0, 1, 0, 0);
    cycle();
    chk("flush_stall", 32'(bus.de_valid), 32'h0);
    bus.imemload = 32'hDEAD_BEEF;
    drive(0, 0, 1, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      bus.imemload = $urandom;
      cycle();
      chk("stall_instr", bus.de_instr, 32'hDEAD_BEEF);
      chk("stall_npc", bus.de_npc, 32'h4);
    end

    // Halt at 0x3C wins over a jump in the same cycle and afterwards.
    drive(0, 0, 0, 0, 0, 1);
    cycle();
    drive(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20 && bus.imemaddr != 32'h3C; i++) cycle();
    chk("reach_3c", bus.imemaddr, 32'h3C);
    drive(1, 2, 1, 0, 1, 0);
    cycle();
    chk("halt_iren", 32'(bus.iREN), 32'h0);
    drive(1, 2, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("halt_pc", bus.imemaddr, 32'h3C);
    end
    drive(1, 2, 1, 0, 0, 1);
    cycle();
    chk("rst_pc", bus.imemaddr, 32'h0);
    chk("rst_iren", 32'(bus.iREN), 32'h1);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      bus.jr_target = $urandom & 32'hFFFF_FFFC;
      bus.br_target = $urandom & 32'hFFFF_FFFC;
      bus.imemload  = $urandom;
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
